riscv_muldiv_unit: RTL

Iterative RV32M/RV64M multiply/divide unit, parametrised in operand width, sitting beside the single-cycle RISC-V ALU in the execute stage. It accepts one M-extension operation through a valid/ready handshake, computes it over multiple cycles with a shift-add multiplier and a restoring divider, and holds the result until the consumer takes it. It also flags RISC-V special cases: divide-by-zero and signed overflow.

---
 rtl/riscv_muldiv_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit
//   Iterative RV32M/RV64M multiply/divide unit for the execute stage.
//   Multiplies are shift-add, one bit of rs2 per cycle, MSB first. Divides
//   use the restoring algorithm, one quotient bit per cycle. Both run on
//   operand magnitudes, and the sign is fixed up on the final iteration.
//   Divide-by-zero and signed overflow skip the datapath entirely.
//
//   Optional build macro: MULDIV_FAST_MUL_EN
//     When defined, all multiplies use a single-cycle signed 2*XLEN
//     multiplier and go straight to DONE.
//
// Ports
//   clk_i, rst_ni      clock, async active-low reset
//   valid_i / ready_o  request handshake (ready_o high only in IDLE)
//   op_i               funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   a_i, b_i           rs1 / rs2 operands
//   flush_i            synchronous abort; wins over valid_i and ready_i
//   valid_o / ready_i  result handshake
//   result_o           result, held while the consumer stalls
//   dz_o, ovf_o        divide-by-zero / signed-overflow flags
module riscv_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            dz_o,
    output logic            ovf_o
);

    localparam int              CW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    state_t state_q, state_d;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic              neg_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   result_q;
    logic              valid_q, dz_q, ovf_q;

    // ---------------- request decode ----------------
    logic            accept, is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic            b_zero, ovf_case, special, fast_mul;
    logic [XLEN-1:0] a_mag, b_mag, spec_res, fast_res;

    assign accept   = valid_i & (state_q == IDLE) & ~flush_i;
    assign is_div   = op_i[2];
    // rs1 is signed for MULH, MULHSU, DIV and REM. rs2 is signed for MULH, DIV and REM.
    assign a_sgn    = (op_i == 3'b001) | (op_i == 3'b010) | (op_i == 3'b100) | (op_i == 3'b110);
    assign b_sgn    = (op_i == 3'b001) | (op_i == 3'b100) | (op_i == 3'b110);
    assign a_neg    = a_sgn & a_i[XLEN-1];
    assign b_neg    = b_sgn & b_i[XLEN-1];
    assign a_mag    = a_neg ? -a_i : a_i;
    assign b_mag    = b_neg ? -b_i : b_i;
    assign b_zero   = (b_i == '0);
    assign ovf_case = is_div & ~op_i[0] & (a_i == MIN_NEG) & (b_i == '1);
    assign special  = is_div & (b_zero | ovf_case);
    // op_i[1] selects remainder (REM/REMU) over quotient (DIV/DIVU).
    assign spec_res = b_zero ? (op_i[1] ? a_i : '1)
                             : (op_i[1] ? '0  : a_i);

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extend both operands by one bit so that a single signed multiply
    // covers MULHU and MULHSU as well as the signed forms.
    logic signed [2*XLEN+1:0] fa_x, fb_x, fprod;
    assign fa_x     = {{(XLEN+1){a_neg}}, a_neg, a_i};
    assign fb_x     = {{(XLEN+1){b_neg}}, b_neg, b_i};
    assign fprod    = fa_x * fb_x;
    assign fast_mul = ~op_i[2];
    assign fast_res = (op_i[1:0] == 2'b00) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`else
    assign fast_mul = 1'b0;
    assign fast_res = '0;
`endif

    // ---------------- iteration datapath ----------------
    // Multiply: acc = (acc << 1) + (b[cnt] ? a : 0), consuming rs2 MSB first.
    // Divide:   acc = {remainder, dividend/quotient}. Each step shifts one
    //           dividend bit into the remainder and keeps the subtract if
    //           it does not go negative.
    logic [XLEN-1:0]   mul_addend, div_sel, fin_div, fin_mul, fin;
    logic [2*XLEN-1:0] mul_next, mul_signed, div_next, acc_next;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ge;

    assign mul_addend = b_q[cnt_q] ? a_q : '0;
    assign mul_next   = {acc_q[2*XLEN-2:0], 1'b0} + {{XLEN{1'b0}}, mul_addend};
    assign div_shift  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff   = div_shift - {1'b0, b_q};
    assign div_ge     = ~div_diff[XLEN];
    assign div_next   = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                         acc_q[XLEN-2:0], div_ge};
    assign acc_next   = op_q[2] ? div_next : mul_next;

    // Sign correction is applied to the last iteration's value directly, so
    // the result is registered on the same edge that ends BUSY.
    assign mul_signed = neg_q ? -mul_next : mul_next;
    assign fin_mul    = (op_q[1:0] == 2'b00) ? mul_signed[XLEN-1:0] : mul_signed[2*XLEN-1:XLEN];
    assign div_sel    = op_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
    assign fin_div    = neg_q ? -div_sel : div_sel;
    assign fin        = op_q[2] ? fin_div : fin_mul;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (special | fast_mul) ? DONE : BUSY;
            BUSY:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (valid_q & ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            // valid_o trails DONE entry by one cycle, which sets the
            // accept-to-valid latency of both the special-case path and
            // the iterative path.
            valid_q <= (state_q == DONE) & ~(valid_q & ready_i) & ~flush_i;
            if (flush_i) begin
                dz_q  <= 1'b0;
                ovf_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (valid_i) begin
                        op_q  <= op_i;
                        a_q   <= a_mag;
                        b_q   <= b_mag;
                        // A remainder takes the dividend's sign. Everything else takes the XOR of both signs.
                        neg_q <= (is_div & op_i[1]) ? a_neg : (a_neg ^ b_neg);
                        acc_q <= is_div ? {{XLEN{1'b0}}, a_mag} : '0;
                        cnt_q <= CW'(XLEN-1);
                        dz_q  <= is_div & b_zero;
                        ovf_q <= ovf_case;
                        if (special)       result_q <= spec_res;
                        else if (fast_mul) result_q <= fast_res;
                    end
                    BUSY: begin
                        acc_q <= acc_next;
                        if (cnt_q == '0) result_q <= fin;
                        else             cnt_q    <= cnt_q - CW'(1);
                    end
                    DONE: if (valid_q & ready_i) begin
                        dz_q  <= 1'b0;
                        ovf_q <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign dz_o     = dz_q;
    assign ovf_o    = ovf_q;

endmodule
